// File: rtl/sram_port_arbiter_if.sv
// Bus bundle for sram_port_arbiter: CPU port, loader port and SRAM pin signals.
// The arbiter connects to the slave modport; requesters and the pad model use master.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;

    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic [DATA_W-1:0] ldr_rdata;
    logic              ldr_ack;

    logic              Mem_CE;
    logic              Mem_UB;
    logic              Mem_LB;
    logic              Mem_OE;
    logic              Mem_WE;
    logic [ADDR_W-1:0] Mem_ADDR;
    logic [DATA_W-1:0] Mem_DQ_out;
    logic              Mem_DQ_oe;
    logic [DATA_W-1:0] Mem_DQ_in;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_rdata, ldr_ack,
        output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_ADDR, Mem_DQ_out, Mem_DQ_oe,
        input  Mem_DQ_in
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_rdata, ldr_ack,
        input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_ADDR, Mem_DQ_out, Mem_DQ_oe,
        output Mem_DQ_in
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one asynchronous SRAM between the CPU memory path and the loader port.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise the CPU has fixed priority.
module sram_port_arbiter #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    sram_port_arbiter_if.slave bus
);
    localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              win_ldr;
    logic              lat_we;

    logic              sel_ldr;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef SRAM_ARB_RR_EN
    logic              last_ldr;
`endif

    always_comb begin
        sel_ldr = !bus.cpu_req;
`ifdef SRAM_ARB_RR_EN
        if (bus.cpu_req && bus.ldr_req)
            sel_ldr = !last_ldr;
`endif
        sel_we    = sel_ldr ? bus.ldr_we    : bus.cpu_we;
        sel_addr  = sel_ldr ? bus.ldr_addr  : bus.cpu_addr;
        sel_wdata = sel_ldr ? bus.ldr_wdata : bus.cpu_wdata;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= IDLE;
            cnt            <= '0;
            win_ldr        <= 1'b0;
            lat_we         <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            last_ldr       <= 1'b1;
`endif
            bus.cpu_ack    <= 1'b0;
            bus.ldr_ack    <= 1'b0;
            bus.cpu_rdata  <= '0;
            bus.ldr_rdata  <= '0;
            bus.Mem_CE     <= 1'b1;
            bus.Mem_OE     <= 1'b1;
            bus.Mem_WE     <= 1'b1;
            bus.Mem_UB     <= 1'b1;
            bus.Mem_LB     <= 1'b1;
            bus.Mem_ADDR   <= '0;
            bus.Mem_DQ_out <= '0;
            bus.Mem_DQ_oe  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_req || bus.ldr_req) begin
                        // Controls for the first ACCESS cycle are set here so every pin stays registered
                        state         <= ACCESS;
                        win_ldr       <= sel_ldr;
                        lat_we        <= sel_we;
                        cnt           <= sel_we ? CNT_W'(WR_CYCLES) : CNT_W'(RD_CYCLES);
                        bus.Mem_ADDR  <= sel_addr;
                        bus.Mem_CE    <= 1'b0;
                        bus.Mem_UB    <= 1'b0;
                        bus.Mem_LB    <= 1'b0;
                        bus.Mem_OE    <= sel_we;
                        bus.Mem_WE    <= !sel_we;
                        bus.Mem_DQ_oe <= sel_we;
                        if (sel_we)
                            bus.Mem_DQ_out <= sel_wdata;
                    end
                end
                ACCESS: begin
                    if (cnt == CNT_W'(1)) begin
                        state         <= DONE;
                        bus.Mem_CE    <= 1'b1;
                        bus.Mem_UB    <= 1'b1;
                        bus.Mem_LB    <= 1'b1;
                        bus.Mem_OE    <= 1'b1;
                        bus.Mem_WE    <= 1'b1;
                        bus.Mem_DQ_oe <= 1'b0;
                        if (win_ldr) bus.ldr_ack <= 1'b1;
                        else         bus.cpu_ack <= 1'b1;
                        if (!lat_we) begin
                            if (win_ldr) bus.ldr_rdata <= bus.Mem_DQ_in;
                            else         bus.cpu_rdata <= bus.Mem_DQ_in;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    bus.cpu_ack <= 1'b0;
                    bus.ldr_ack <= 1'b0;
`ifdef SRAM_ARB_RR_EN
                    last_ldr    <= win_ldr;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: directed requests, SRAM pad model, and a
// second instance with RD_CYCLES=4 / WR_CYCLES=1 for timing-parameter checks.
module tb_sram_port_arbiter;
    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    sram_port_arbiter_if #(.ADDR_W(20), .DATA_W(16)) if1 ();
    sram_port_arbiter_if #(.ADDR_W(20), .DATA_W(16)) if2 ();

    sram_port_arbiter #(.ADDR_W(20), .DATA_W(16), .RD_CYCLES(2), .WR_CYCLES(2)) dut (
        .Clk(Clk), .Reset(Reset), .bus(if1)
    );

    sram_port_arbiter #(.ADDR_W(20), .DATA_W(16), .RD_CYCLES(4), .WR_CYCLES(1)) dut2 (
        .Clk(Clk), .Reset(Reset), .bus(if2)
    );

    // Small SRAM model indexed by the low address byte; test addresses are distinct there
    logic [15:0] mem [0:255];
    always @(posedge Clk)
        if (!if1.Mem_CE && !if1.Mem_WE)
            mem[if1.Mem_ADDR[7:0]] <= if1.Mem_DQ_out;
    assign if1.Mem_DQ_in = (!if1.Mem_CE && !if1.Mem_OE) ? mem[if1.Mem_ADDR[7:0]] : 16'h0000;
    assign if2.Mem_DQ_in = (!if2.Mem_CE && !if2.Mem_OE) ? 16'hC0DE : 16'h0000;

    typedef struct {
        bit          ldr;
        bit          rd;
        logic [15:0] data;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_acks = 0;
    int   n_prot = 0;
    logic [15:0] mc = '0;
    logic [15:0] ml = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input bit ldr, input bit rd, input logic [15:0] data);
        sbq.push_back('{ldr, rd, data});
    endtask

    always @(negedge Clk) begin
        if (Reset) begin
            mc = '0;
            ml = '0;
        end else if (if1.cpu_ack || if1.ldr_ack) begin
            n_acks++;
            chk("dual_ack", 32'(if1.cpu_ack & if1.ldr_ack), 0);
            if (sbq.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_ack: got cpu_ack=%b ldr_ack=%b, expected none", if1.cpu_ack, if1.ldr_ack);
            end else begin
                mon_e = sbq.pop_front();
                chk("ack_port", 32'(if1.ldr_ack), 32'(mon_e.ldr));
                if (mon_e.rd) begin
                    if (mon_e.ldr) ml = mon_e.data;
                    else           mc = mon_e.data;
                end
                chk("cpu_rdata", 32'(if1.cpu_rdata), 32'(mc));
                chk("ldr_rdata", 32'(if1.ldr_rdata), 32'(ml));
            end
        end
        if (!if1.Mem_OE && !if1.Mem_WE) n_prot++;
        if (if1.Mem_DQ_oe && !if1.Mem_OE) n_prot++;
        if (!if2.Mem_OE && !if2.Mem_WE) n_prot++;
        if (if2.Mem_DQ_oe && !if2.Mem_OE) n_prot++;
    end

    task automatic do_req(input bit ldr, input bit we, input logic [19:0] addr, input logic [15:0] wd,
                          input int exp_lat, input int exp_oe, input int exp_we);
        int k  = 0;
        int oe = 0;
        int wl = 0;
        bit got = 0;
        if (ldr) begin
            if1.ldr_we = we; if1.ldr_addr = addr; if1.ldr_wdata = wd; if1.ldr_req = 1'b1;
        end else begin
            if1.cpu_we = we; if1.cpu_addr = addr; if1.cpu_wdata = wd; if1.cpu_req = 1'b1;
        end
        while (!got && k < 60) begin
            @(negedge Clk);
            k++;
            if (!if1.Mem_OE) oe++;
            if (!if1.Mem_WE) wl++;
            got = ldr ? if1.ldr_ack : if1.cpu_ack;
        end
        chk("ack_timeout", 32'(got), 1);
        @(posedge Clk);
        #1;
        if (ldr) if1.ldr_req = 1'b0;
        else     if1.cpu_req = 1'b0;
        if (got) begin
            if (exp_lat > 0)  chk("latency", k, exp_lat);
            if (exp_oe >= 0)  chk("oe_low_cycles", oe, exp_oe);
            if (exp_we >= 0)  chk("we_low_cycles", wl, exp_we);
        end
    endtask

    task automatic wait_acks(input int target);
        int k = 0;
        while (n_acks < target && k < 200) begin
            @(posedge Clk);
            #1;
            k++;
        end
        chk("ack_count", n_acks, target);
    endtask

    task automatic d2_req(input bit we, input int exp_lat, input int exp_oe, input int exp_we);
        int k  = 0;
        int oe = 0;
        int wl = 0;
        bit got = 0;
        if2.cpu_we = we; if2.cpu_addr = 20'h00005; if2.cpu_wdata = 16'h0001; if2.cpu_req = 1'b1;
        while (!got && k < 60) begin
            @(negedge Clk);
            k++;
            if (!if2.Mem_OE) oe++;
            if (!if2.Mem_WE) wl++;
            got = if2.cpu_ack;
        end
        chk("d2_ack_timeout", 32'(got), 1);
        @(posedge Clk);
        #1;
        if2.cpu_req = 1'b0;
        if (got) begin
            chk("d2_latency", k, exp_lat);
            chk("d2_oe_low_cycles", oe, exp_oe);
            chk("d2_we_low_cycles", wl, exp_we);
            if (!we) chk("d2_rdata", 32'(if2.cpu_rdata), 32'h0000C0DE);
        end
    endtask

    initial begin
        int base;
        Reset = 1'b1;
        if1.cpu_req = 0; if1.cpu_we = 0; if1.cpu_addr = '0; if1.cpu_wdata = '0;
        if1.ldr_req = 0; if1.ldr_we = 0; if1.ldr_addr = '0; if1.ldr_wdata = '0;
        if2.cpu_req = 0; if2.cpu_we = 0; if2.cpu_addr = '0; if2.cpu_wdata = '0;
        if2.ldr_req = 0; if2.ldr_we = 0; if2.ldr_addr = '0; if2.ldr_wdata = '0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        chk("idle_ctrl", 32'({if1.Mem_CE, if1.Mem_OE, if1.Mem_WE, if1.Mem_UB, if1.Mem_LB}), 32'h1F);
        chk("idle_dq_oe", 32'(if1.Mem_DQ_oe), 0);
        chk("idle_addr", 32'(if1.Mem_ADDR), 0);
        chk("idle_dq_out", 32'(if1.Mem_DQ_out), 0);
        chk("idle_acks", 32'({if1.cpu_ack, if1.ldr_ack}), 0);
        chk("idle_rdata", 32'({if1.cpu_rdata, if1.ldr_rdata}), 0);
        chk("idle_ack_count", n_acks, 0);

        // Both requesters raised together and held; writes to scratch addresses 0x40/0x41
        base = n_acks;
        if1.cpu_we = 1; if1.cpu_addr = 20'h00040; if1.cpu_wdata = 16'hAAAA;
        if1.ldr_we = 1; if1.ldr_addr = 20'h00041; if1.ldr_wdata = 16'h5555;
`ifdef SRAM_ARB_RR_EN
        push(0, 0, '0); push(1, 0, '0); push(0, 0, '0); push(1, 0, '0);
        if1.cpu_req = 1; if1.ldr_req = 1;
        wait_acks(base + 4);
        if1.cpu_req = 0; if1.ldr_req = 0;
`else
        push(0, 0, '0); push(0, 0, '0); push(0, 0, '0); push(0, 0, '0); push(1, 0, '0);
        if1.cpu_req = 1; if1.ldr_req = 1;
        wait_acks(base + 4);
        if1.cpu_req = 0;
        wait_acks(base + 5);
        if1.ldr_req = 0;
`endif
        repeat (2) @(posedge Clk);
        #1;

        push(0, 0, '0);
        do_req(0, 1, 20'h00012, 16'hBEEF, 4, 0, 2);
        push(0, 1, 16'hBEEF);
        do_req(0, 0, 20'h00012, 16'h0000, 4, 2, 0);
        push(1, 0, '0);
        do_req(1, 1, 20'hFFFFF, 16'h5A5A, 4, 0, 2);
        push(0, 0, '0);
        do_req(0, 1, 20'h00000, 16'h1234, 4, 0, 2);

        // Simultaneous reads; last completed grant was the CPU
`ifdef SRAM_ARB_RR_EN
        push(1, 1, 16'h5A5A); push(0, 1, 16'h1234);
`else
        push(0, 1, 16'h1234); push(1, 1, 16'h5A5A);
`endif
        fork
            do_req(0, 0, 20'h00000, 16'h0000, 0, -1, -1);
            do_req(1, 0, 20'hFFFFF, 16'h0000, 0, -1, -1);
        join
        repeat (2) @(posedge Clk);
        #1;

        // Reset during the second ACCESS cycle of a write: no ack may follow
        if1.cpu_we = 1; if1.cpu_addr = 20'h00077; if1.cpu_wdata = 16'h1111; if1.cpu_req = 1;
        repeat (2) @(posedge Clk);
        #1;
        chk("abort_we_low", 32'(if1.Mem_WE), 0);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        chk("abort_we_high", 32'(if1.Mem_WE), 1);
        chk("abort_ce_high", 32'(if1.Mem_CE), 1);
        chk("abort_no_ack", 32'({if1.cpu_ack, if1.ldr_ack}), 0);
        chk("abort_rdata_reset", 32'({if1.cpu_rdata, if1.ldr_rdata}), 0);
        Reset = 1'b0;
        if1.cpu_req = 0;
        repeat (3) @(posedge Clk);
        #1;
        push(0, 1, 16'hBEEF);
        do_req(0, 0, 20'h00012, 16'h0000, 4, 2, 0);

        d2_req(0, 6, 4, 0);
        d2_req(1, 3, 0, 1);

        repeat (2) @(posedge Clk);
        #1;
        chk("protocol_violations", n_prot, 0);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Sequences and shares the single asynchronous 16-bit SRAM between two requesters: the CPU memory path (MAR/MDR loads issued by the instruction sequencer) and a program-loader/debug port. It owns every SRAM control pin and runs multi-cycle read and write cycles. It grants one requester at a time and returns a one-cycle acknowledge with read data. It sits between the CPU datapath, the loader and the board SRAM pins.

## Interface
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, SRAM data width
- RD_CYCLES, 2, cycles OE held low per read (minimum 1)
- WR_CYCLES, 2, cycles WE held low per write (minimum 1)
- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; sampled at grant
- cpu_addr  in  ADDR_W  word address; sampled at grant
- cpu_wdata  in  DATA_W  write data; sampled at grant
- cpu_rdata  out  DATA_W  read data; valid in the cpu_ack cycle, held until the next CPU read completes
- cpu_ack  out  1  one-cycle completion pulse
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdata, ldr_ack: loader port; same directions, widths and rules as the cpu_* signals
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  SRAM controls, active-low
- Mem_ADDR  out  ADDR_W  registered SRAM address
- Mem_DQ_out  out  DATA_W  write data to the pad driver
- Mem_DQ_oe  out  1  1 = drive DQ pads (writes only)
- Mem_DQ_in  in  DATA_W  data from the DQ pads

## Operation
- FSM states: IDLE, ACCESS, DONE. A down-counter of width clog2(max(RD_CYCLES,WR_CYCLES))+1 paces ACCESS.
- IDLE: when any req is high, pick a winner. Latch its we, addr and wdata. Load the counter with RD_CYCLES or WR_CYCLES. Go to ACCESS.
- ACCESS (read):
  - Mem_CE=0, Mem_UB=Mem_LB=0, Mem_OE=0, Mem_WE=1, Mem_DQ_oe=0.
  - In the last counted cycle, capture Mem_DQ_in into the winner's rdata register.
- ACCESS (write):
  - Mem_CE=0, Mem_UB=Mem_LB=0, Mem_WE=0, Mem_OE=1, Mem_DQ_oe=1.
  - Mem_DQ_out holds the latched data.
- On the last ACCESS cycle, go to DONE.
- DONE:
  - Pulse the winner's ack for exactly one cycle.
  - Mem_CE=1, Mem_OE=1, Mem_WE=1, Mem_DQ_oe=0.
  - Mem_ADDR and Mem_DQ_out stay unchanged, which gives the SRAM hold time.
  - Then go to IDLE.
- Handshake:
  - A requester deasserts req on the edge that ends its ack cycle.
  - Any req seen high in IDLE is a new request.
  - Changing addr, we or wdata while a request is pending and ungranted is allowed. Values are sampled only at grant.
- The loser of a simultaneous request stays pending with no ack. It is served on the next IDLE.
- Addresses wrap naturally; there is no range check.
- Reset asserted in any state:
  - Next state is IDLE. No ack is issued for the aborted access.
  - All outputs return to their reset values at that edge.
  - The priority pointer resets to "loader last", so the CPU wins first.
- Reset values:
  - cpu_ack=0, ldr_ack=0, cpu_rdata=0, ldr_rdata=0.
  - Mem_CE=1, Mem_OE=1, Mem_WE=1, Mem_UB=1, Mem_LB=1.
  - Mem_ADDR=0, Mem_DQ_out=0, Mem_DQ_oe=0.

## Timing
- Request first seen high in IDLE at cycle t: ACCESS runs t+1 … t+N (N = RD_CYCLES or WR_CYCLES). Ack is at t+N+1.
- Read latency = RD_CYCLES+2 cycles, req-to-ack.
- Write latency = WR_CYCLES+2 cycles, req-to-ack.
- Back-to-back accesses: minimum spacing is N+2 cycles, because IDLE is always visited.
- Mem_OE and Mem_WE are never low in the same cycle.
- Mem_DQ_oe is never 1 while Mem_OE=0.
- All Mem_* outputs are registered (glitch-free).

## Configuration
- SRAM_ARB_RR_EN defined: round-robin arbitration. A one-bit last-grant register flips the priority after each completed access, so two continuous requesters alternate.
- SRAM_ARB_RR_EN undefined: fixed priority, where the CPU always wins a simultaneous request. The last-grant register is removed. The loader can starve.

## Test plan
- Reset, then idle for 10 cycles → all Mem_* controls 1, Mem_DQ_oe=0, no ack.
- CPU write addr 0x00012, data 0xBEEF, then CPU read of 0x00012 (RD/WR=2):
  - write → Mem_WE=0 for 2 cycles, cpu_ack 4 cycles after req.
  - read → cpu_rdata=0xBEEF on a cpu_ack 4 cycles after req.
- cpu_req and ldr_req both raised in the same cycle, held continuously:
  - RR_EN: grants CPU, LDR, CPU, LDR.
  - Without RR_EN: only CPU acks while cpu_req stays high.
- Loader read of 0xFFFFF while a CPU read of 0x00000 is pending → each port gets only its own data. The other port's rdata and ack are unchanged.
- Reset pulsed in the second ACCESS cycle of a write → Mem_WE=1 at the next edge, no ack, next CPU request granted normally.
- RD_CYCLES=4, WR_CYCLES=1 → read latency 6 cycles with OE low for 4, write latency 3 cycles with WE low for 1.
